div_seq: RTL and testbench

Iterative 32-bit integer divider for the MIPS datapath implementing DIV and DIVU. It accepts dividend and divisor on a start strobe and runs one restoring-division step per clock. It returns quotient (LO) and remainder (HI) as registered results with a one-cycle done pulse. It is the counterpart of the combinational multiplier feeding HI/LO: the multiplier packs a 64-bit product, while this block produces the quotient/remainder pair the HI/LO registers capture.

---
 rtl/div_seq.sv | 130 +++++++++++++
 tb/tb_div_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// quotient to LO and remainder to HI, with a one-cycle done pulse.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH:0]   prem_reg;
    logic [WIDTH-1:0] qreg_reg;
    logic [WIDTH-1:0] bmag_reg;
    logic [WIDTH-1:0] a_raw_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             b_zero_reg;

    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   restore;

    assign amag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign bmag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Trial subtraction is one bit wider than the remainder so its MSB is the borrow.
    assign trial   = {prem_reg, qreg_reg[WIDTH-1]} - {2'b00, bmag_reg};
    assign restore = {prem_reg[WIDTH-1:0], qreg_reg[WIDTH-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg  <= '0;
            prem_reg   <= '0;
            qreg_reg   <= '0;
            bmag_reg   <= '0;
            a_raw_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            done       <= 1'b0;
            quo        <= '0;
            rem        <= '0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_raw_reg  <= a;
                        bmag_reg   <= bmag;
                        b_zero_reg <= (b == '0);
                        neg_q_reg  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_reg  <= is_signed & a[WIDTH-1];
                        prem_reg   <= '0;
                        qreg_reg   <= amag;
                        count_reg  <= '0;
                    end
                end
                RUN: begin
                    prem_reg  <= trial[WIDTH+1] ? restore : trial[WIDTH:0];
                    qreg_reg  <= {qreg_reg[WIDTH-2:0], ~trial[WIDTH+1]};
                    count_reg <= count_reg + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (b_zero_reg) begin
                        quo      <= '1;
                        rem      <= a_raw_reg;
                        div_zero <= 1'b1;
                    end else begin
                        quo      <= neg_q_reg ? -qreg_reg : qreg_reg;
                        rem      <= neg_r_reg ? -prem_reg[WIDTH-1:0] : prem_reg[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: fixed vector table, hand-written timing corner cases and
// randomized operands checked against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] quo, rem;

    int n_vec  = 0;
    int n_miss = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input bit s, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (bv == 32'd0) begin
            q = 32'hFFFF_FFFF; r = av; dz = 1'b1;
        end else if (s) begin
            sa = {{32{av[31]}}, av};
            sb = {{32{bv[31]}}, bv};
            q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
        end else begin
            q = av / bv; r = av % bv; dz = 1'b0;
        end
    endtask

    // Waits for done after the start edge; 'first' is the index of the next edge.
    task automatic wait_done(input int first, output int lat);
        lat = -1;
        for (int i = first; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_div(input bit s, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] q, output logic [31:0] r, output logic dz,
                           output int lat);
        @(negedge clk);
        is_signed = s; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(1, lat);
        q = quo; r = rem; dz = div_zero;
        check("busy_after_fix", {31'd0, busy}, 32'd0);
    endtask

    vec_t        tbl[9];
    logic [31:0] q, r, eq, er;
    logic        dz, edz;
    int          lat;
    logic [31:0] ra, rb;
    bit          rs;

    initial begin
        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        tbl[5] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        tbl[6] = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1};
        tbl[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quo", quo, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors
        foreach (tbl[i]) begin
            run_div(tbl[i].s, tbl[i].a, tbl[i].b, q, r, dz, lat);
            $display("vec %0d: s=%0d a=%h b=%h -> quo=%h rem=%h dz=%0d lat=%0d",
                     i, tbl[i].s, tbl[i].a, tbl[i].b, q, r, dz, lat);
            check("tbl_lat", lat, 33);
            check("tbl_quo", q, tbl[i].q);
            check("tbl_rem", r, tbl[i].r);
            check("tbl_dz", {31'd0, dz}, {31'd0, tbl[i].dz});
        end

        // done lasts one cycle
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // start re-pulsed at T5 is ignored
        @(negedge clk);
        is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        is_signed = 1'b1; a = 32'd5; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_quo_in_run", quo, 32'd14);
        wait_done(6, lat);
        $display("repulse: quo=%h rem=%h lat=%0d", quo, rem, lat);
        check("repulse_lat", lat, 33);
        check("repulse_quo", quo, 32'd14);
        check("repulse_rem", rem, 32'd2);

        // start during the done cycle begins the next division
        is_signed = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_old_quo", quo, 32'd14);
        wait_done(1, lat);
        $display("back2back: quo=%h rem=%h lat=%0d", quo, rem, lat);
        check("b2b_lat", lat, 33);
        check("b2b_quo", quo, 32'hFFFF_FFF2);
        check("b2b_rem", rem, 32'hFFFF_FFFE);

        // Asynchronous reset at T10 aborts the division
        @(negedge clk);
        is_signed = 1'b0; a = 32'd999; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        $display("mid reset: busy=%0d done=%0d quo=%h rem=%h dz=%0d", busy, done, quo, rem, div_zero);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_quo", quo, 32'd0);
        check("mrst_rem", rem, 32'd0);
        check("mrst_dz", {31'd0, div_zero}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check("mrst_no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, q, r, dz, lat);
        $display("after reset: quo=%h rem=%h lat=%0d", q, r, lat);
        check("post_rst_lat", lat, 33);
        check("post_rst_quo", q, 32'd14);
        check("post_rst_rem", r, 32'd2);

        // Randomized operands against the reference model
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_div(rs, ra, rb, q, r, dz, lat);
            model(rs, ra, rb, eq, er, edz);
            $display("rnd %0d: s=%0d a=%h b=%h -> quo=%h rem=%h dz=%0d lat=%0d",
                     i, rs, ra, rb, q, r, dz, lat);
            check("rnd_lat", lat, 33);
            check("rnd_quo", q, eq);
            check("rnd_rem", r, er);
            check("rnd_dz", {31'd0, dz}, {31'd0, edz});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
